// File: rtl/exc_redirect_if.sv
// Signal bundle between the redirect controller, the exception unit and the IF stage.
// The controller takes the slave side; the surrounding pipeline (or a bench) takes the master side.
interface exc_redirect_if;
    logic        exc_req;
    logic [31:0] exc_target;
    logic        exc_ready;
    logic        if_req_fire;
    logic        if_data_ok;
    logic        if_can_req;
    logic        drop_resp;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;

    modport slave (
        input  exc_req, exc_target, if_req_fire, if_data_ok, redirect_ready,
        output exc_ready, if_can_req, drop_resp, flush, redirect_valid, redirect_pc, busy
    );

    modport master (
        output exc_req, exc_target, if_req_fire, if_data_ok, redirect_ready,
        input  exc_ready, if_can_req, drop_resp, flush, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/exc_redirect_ctrl.sv
// Front-end redirect sequencer: flushes on an exception/ERET, drains in-flight
// inst-SRAM responses, then hands the new PC to fetch over valid/ready.
module exc_redirect_ctrl #(
    parameter  int MAX_OUTSTANDING = 2,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic           clk,
    input  logic           resetn,
    exc_redirect_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_REDIRECT
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [31:0]        r_target;
    logic               r_flush;
    logic               w_exc_fire;
    logic               w_inc;
    logic               w_dec;
    logic               w_cnt_full;

    // Outstanding count: responses at zero are stray, requests at the limit saturate.
    assign w_cnt_full = (r_cnt == CNT_W'(MAX_OUTSTANDING));
    assign w_dec      = bus.if_data_ok & (r_cnt != '0);
    assign w_inc      = bus.if_req_fire & ~(w_cnt_full & ~w_dec);
    assign w_cnt_next = r_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);

    assign w_exc_fire = bus.exc_req & (r_state != ST_REDIRECT);

    assign bus.flush       = r_flush;
    assign bus.redirect_pc = r_target;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        bus.exc_ready      = 1'b1;
        bus.if_can_req     = 1'b0;
        bus.drop_resp      = bus.if_data_ok & w_exc_fire;
        bus.redirect_valid = 1'b0;
        bus.busy           = 1'b1;
        case (r_state)
            ST_IDLE: begin
                bus.busy       = 1'b0;
                bus.if_can_req = (r_cnt < CNT_W'(MAX_OUTSTANDING));
                if (w_exc_fire) begin
                    w_state_next = (w_cnt_next != '0) ? ST_DRAIN : ST_REDIRECT;
                end
            end
            ST_DRAIN: begin
                bus.drop_resp = bus.if_data_ok;
                if (w_cnt_next == '0) begin
                    w_state_next = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                // The request stays blocked so the source holds it until we return to IDLE.
                bus.exc_ready      = 1'b0;
                bus.redirect_valid = 1'b1;
                if (bus.redirect_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_target <= '0;
            r_flush  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_flush <= w_exc_fire;
            if (w_exc_fire) begin
                r_target <= bus.exc_target;
            end
        end
    end

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Bench for exc_redirect_ctrl: directed scenarios plus random traffic against a
// transaction-level model, with redirect handshakes checked by a separate monitor.
module tb_exc_redirect_ctrl;

    localparam int MAX = 2;

    logic clk;
    logic resetn;

    exc_redirect_if bus ();

    exc_redirect_ctrl #(.MAX_OUTSTANDING(MAX)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: outstanding fetches, whether we wait for them to drain, whether a PC is on offer.
    int          m_out        = 0;
    bit          m_draining   = 0;
    bit          m_presenting = 0;
    bit          m_fire_prev  = 0;
    logic [31:0] exp_pc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
    task automatic cycle(input bit req, input logic [31:0] tgt, input bit rf, input bit dok, input bit rdy);
        bit fire;
        int n;
        bus.exc_req        = req;
        bus.exc_target     = tgt;
        bus.if_req_fire    = rf;
        bus.if_data_ok     = dok;
        bus.redirect_ready = rdy;
        fire = req && !m_presenting;
        @(negedge clk);
        chk("exc_ready", 32'(bus.exc_ready), 32'(!m_presenting));
        chk("if_can_req", 32'(bus.if_can_req), 32'((m_out < MAX) && !m_draining && !m_presenting));
        chk("drop_resp", 32'(bus.drop_resp), 32'(dok && (m_draining || fire)));
        chk("flush", 32'(bus.flush), 32'(m_fire_prev));
        chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_presenting));
        chk("busy", 32'(bus.busy), 32'(m_draining || m_presenting));
        if (m_presenting && exp_pc_q.size() > 0) chk("redirect_pc_hold", bus.redirect_pc, exp_pc_q[0]);
        n = m_out + (rf ? 1 : 0) - ((dok && m_out > 0) ? 1 : 0);
        if (n > MAX) n = MAX;
        if (fire) begin
            if (!m_draining) exp_pc_q.push_back(tgt);
            else exp_pc_q[exp_pc_q.size()-1] = tgt;
            m_draining   = (n != 0);
            m_presenting = (n == 0);
        end else if (m_draining && n == 0) begin
            m_draining   = 0;
            m_presenting = 1;
        end else if (m_presenting && rdy) begin
            m_presenting = 0;
        end
        m_out       = n;
        m_fire_prev = fire;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted redirect must match the oldest expected PC.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (resetn && bus.redirect_valid && bus.redirect_ready) begin
                if (exp_pc_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL redirect_unexpected: got pc %0h expected no handshake", bus.redirect_pc);
                end else begin
                    chk("redirect_pc", bus.redirect_pc, exp_pc_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit          rf;
        bit          dok;
        logic [31:0] tgt;
        bus.exc_req        = 1'b0;
        bus.exc_target     = '0;
        bus.if_req_fire    = 1'b0;
        bus.if_data_ok     = 1'b0;
        bus.redirect_ready = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rst_exc_ready", 32'(bus.exc_ready), 32'd1);
        chk("rst_if_can_req", 32'(bus.if_can_req), 32'd1);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Idle fire with ready tied high
        cycle(1, 32'hBFC00380, 0, 0, 1);
        cycle(0, 32'h0, 0, 0, 1);
        cycle(0, 32'h0, 0, 0, 1);
        cycle(0, 32'h0, 0, 0, 0);

        // Drain two outstanding fetches
        cycle(0, 32'h0, 1, 0, 0);
        cycle(0, 32'h0, 1, 0, 0);
        cycle(1, 32'h1234_5670, 0, 0, 0);
        cycle(0, 32'h0, 0, 0, 0);
        cycle(0, 32'h0, 0, 1, 0);
        cycle(0, 32'h0, 0, 0, 0);
        cycle(0, 32'h0, 0, 1, 0);
        cycle(0, 32'h0, 0, 0, 1);
        cycle(0, 32'h0, 0, 0, 0);

        // Fetch accepted in the same cycle as the fire
        cycle(1, 32'h0000_2000, 1, 0, 0);
        cycle(0, 32'h0, 0, 1, 0);
        cycle(0, 32'h0, 0, 0, 1);
        cycle(0, 32'h0, 0, 0, 0);

        // Backpressure with a blocked request, then the held request is taken in IDLE
        cycle(1, 32'h0000_4000, 0, 0, 0);
        repeat (5) cycle(1, 32'h8000_0180, 0, 0, 0);
        cycle(1, 32'h8000_0180, 0, 0, 1);
        cycle(1, 32'h8000_0180, 0, 0, 0);
        cycle(0, 32'h0, 0, 0, 1);
        cycle(0, 32'h0, 0, 0, 0);

        // Re-fire while one fetch is still outstanding
        cycle(0, 32'h0, 1, 0, 0);
        cycle(1, 32'h0000_6000, 0, 0, 0);
        cycle(1, 32'hBFC00200, 0, 0, 0);
        cycle(0, 32'h0, 0, 1, 0);
        cycle(0, 32'h0, 0, 0, 1);
        cycle(0, 32'h0, 0, 0, 0);

        // Saturation: request while already full
        cycle(0, 32'h0, 1, 0, 0);
        cycle(0, 32'h0, 1, 0, 0);
        cycle(0, 32'h0, 1, 0, 0);
        cycle(0, 32'h0, 0, 1, 0);
        cycle(0, 32'h0, 0, 1, 0);
        cycle(0, 32'h0, 0, 0, 0);

        // Asynchronous reset in the middle of a drain
        cycle(0, 32'h0, 1, 0, 0);
        cycle(0, 32'h0, 1, 0, 0);
        cycle(1, 32'hDEAD_0000, 0, 0, 0);
        cycle(0, 32'h0, 0, 0, 0);
        bus.exc_req        = 1'b0;
        bus.if_req_fire    = 1'b0;
        bus.if_data_ok     = 1'b0;
        bus.redirect_ready = 1'b0;
        #2;
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_flush", 32'(bus.flush), 32'd0);
        chk("arst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("arst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("arst_exc_ready", 32'(bus.exc_ready), 32'd1);
        chk("arst_if_can_req", 32'(bus.if_can_req), 32'd1);
        chk("arst_drop_resp", 32'(bus.drop_resp), 32'd0);
        m_out = 0;
        m_draining = 0;
        m_presenting = 0;
        m_fire_prev = 0;
        exp_pc_q.delete();
        #4;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        cycle(0, 32'h0, 0, 1, 0);
        cycle(0, 32'h0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rf  = (m_out < MAX && !m_draining && !m_presenting) ? ($urandom_range(0, 2) == 0)
                                                                : ($urandom_range(0, 40) == 0);
            dok = (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 20) == 0);
            tgt = $urandom;
            cycle($urandom_range(0, 5) == 0, tgt, rf, dok, $urandom_range(0, 1) == 1);
        end

        // Let everything settle, bounded
        for (int i = 0; i < 20 && (m_draining || m_presenting); i++) begin
            cycle(0, 32'h0, 0, (m_out > 0), 1);
        end
        cycle(0, 32'h0, 0, 0, 0);
        chk("final_queue_empty", 32'(exp_pc_q.size()), 32'd0);
        chk("final_busy", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/exc_redirect_ctrl.md
# exc_redirect_ctrl

Sequences the front-end redirect that follows an exception or ERET. It accepts a redirect request from the exception unit, pulses the pipeline flush, and drains or discards instruction-fetch responses still in flight. It then hands the new PC to the fetch stage through a valid/ready handshake. It sits between the exception unit and the IF stage, and it owns the count of outstanding instruction-SRAM requests.

## Interface
- MAX_OUTSTANDING, 2: maximum number of accepted but unanswered inst-SRAM requests.
- CNT_W, $clog2(MAX_OUTSTANDING+1): width of the outstanding counter. Derived; do not override.

- clk  in  1  core clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- exc_req  in  1  redirect request from the exception unit (exception or ERET)
- exc_target  in  32  new PC; sampled when exc_fire
- exc_ready  out  1  request can be accepted: high in IDLE and DRAIN, low in REDIRECT
- if_req_fire  in  1  IF request accepted by inst SRAM this cycle (req & addr_ok)
- if_data_ok  in  1  inst SRAM returned data this cycle
- if_can_req  out  1  IF may issue a request: (cnt < MAX_OUTSTANDING) & (state == IDLE)
- drop_resp  out  1  combinational; the IF stage must discard the current if_data_ok data
- flush  out  1  registered one-cycle flush pulse to all pipeline stages
- redirect_valid  out  1  new PC is valid for the fetch stage
- redirect_pc  out  32  new PC
- redirect_ready  in  1  fetch stage accepts redirect_pc
- busy  out  1  state != IDLE

## Operation
- exc_fire = exc_req & exc_ready.
- Outstanding counter cnt, CNT_W bits:
  - cnt_next = cnt + if_req_fire − (if_data_ok & cnt != 0).
  - A simultaneous increment and decrement leaves cnt unchanged.
  - if_data_ok while cnt == 0 is ignored.
  - if_req_fire while cnt == MAX_OUTSTANDING is a protocol error; cnt saturates and does not wrap.
  - cnt updates in every state.
- States: IDLE, DRAIN, REDIRECT.
- IDLE:
  - On exc_fire: target <= exc_target and flush <= 1.
  - Next state is DRAIN if cnt_next != 0, else REDIRECT.
  - A fetch accepted in the same cycle as exc_fire is counted and later dropped.
- DRAIN:
  - if_can_req = 0.
  - Each if_data_ok is dropped and decrements cnt.
  - When cnt_next == 0, go to REDIRECT.
  - A new exc_fire in DRAIN overwrites target and pulses flush again; the state transition rule is unchanged.
- REDIRECT:
  - redirect_valid = 1 and redirect_pc = target, both held stable until redirect_ready.
  - On redirect_ready, go to IDLE.
  - exc_ready = 0; exc_req is ignored and must be held by the source.
- drop_resp = if_data_ok & ((state == DRAIN) | exc_fire). In IDLE without exc_fire, data passes through.
- Flush behaviour:
  - flush is 0 in every cycle without a preceding exc_fire.
  - Two back-to-back fires produce two consecutive high cycles.
- Reset (asynchronous, any state, mid-operation included):
  - state = IDLE, cnt = 0, target = 0.
  - flush = 0, redirect_valid = 0, redirect_pc = 0, busy = 0, exc_ready = 1.
  - drop_resp = 0 and if_can_req = 1 while inputs are idle.

## Timing
- redirect_valid and redirect_pc are driven from state and target registers, with no combinational path from exc_req.
- Minimum latency, cnt_next == 0 at fire in cycle T:
  - T+1: flush = 1, redirect_valid = 1.
  - With ready at T+1, back in IDLE at T+2.
- Drain latency: REDIRECT is entered in the cycle after the last outstanding if_data_ok.
- if_can_req drops to 0 in the cycle after exc_fire and returns to 1 in the cycle after the redirect handshake.
- Fetch restarts at the redirect PC from that cycle.
- redirect_ready while redirect_valid == 0 has no effect.

## Test plan
- Idle fire:
  - Stimulus: cnt = 0, exc_req with exc_target = 0xBFC00380 at T, redirect_ready tied high.
  - Required: flush = 1 at T+1 only; redirect_valid = 1 with pc 0xBFC00380 at T+1; busy = 0 at T+2.
- Drain two:
  - Stimulus: two if_req_fire, then exc_fire; if_data_ok at T+2 and T+4.
  - Required: both flagged drop_resp; redirect_valid rises at T+5; if_can_req = 0 from T+1 to the handshake.
- Same-cycle fetch:
  - Stimulus: if_req_fire and exc_fire together with cnt = 0.
  - Required: state DRAIN; the next if_data_ok is dropped; then REDIRECT.
- Backpressure and blocked request:
  - Stimulus: redirect_ready = 0 for 5 cycles; exc_req asserted with target 0x80000180.
  - Required: redirect_pc stays at the original target; exc_ready = 0; no flush.
  - Stimulus: after the handshake, exc_req is still held.
  - Required: the held request is accepted in IDLE.
- Re-fire in DRAIN:
  - Stimulus: a second exc_fire with target 0xBFC00200 while cnt = 1.
  - Required: flush pulses again; the final redirect_pc = 0xBFC00200.
- Reset mid-DRAIN:
  - Stimulus: deassert resetn asynchronously in DRAIN.
  - Required: all outputs reach reset values immediately with no clock edge; cnt = 0; stray if_data_ok after reset is passed through, not dropped.
